// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path.
//
// Contents:
//   IC_BLOCK_WORDS        default number of 32-bit words per cache line
//   IC_OFFSET_W           byte-offset width within a line, log2(IC_BLOCK_WORDS*4)
//   icache_refill_state_t refill controller states
package icache_pkg;

  localparam int IC_BLOCK_WORDS = 4;
  localparam int IC_OFFSET_W    = $clog2(IC_BLOCK_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } icache_refill_state_t;

endpackage

// File: rtl/icache_beat_counter.sv
// Beat counter for a cache-line refill burst.
//
// Counts accepted read beats within one line. The count clears on load and
// wraps to zero after the last beat of the line. The word index adds a start
// offset to the count so that a burst beginning mid-line walks the line in
// wrapping order; with a zero start offset the index equals the count.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset; clears the count
//   load_i     clear the count to 0 (start of a burst)
//   inc_i      advance the count by one beat
//   start_i    word offset of the first beat within the line
//   cnt_o      beats received so far in this burst
//   idx_o      word index within the line for the current beat
module icache_beat_counter #(
  parameter int  WORDS = 4,
  localparam int CW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [CW-1:0] start_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] idx_o
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load_i) begin
      cnt_next = '0;
    end else if (inc_i) begin
      // WORDS is a power of two, so natural overflow is the line wrap.
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;
  // Modular add: wraps inside the line for critical-word-first ordering.
  assign idx_o = cnt_reg + start_i;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller for the fetch stage.
//
// On a fetch miss it issues one burst read for the missing line, writes the
// returned beats into the cache data array, pulses fill-done when the line is
// complete, and stalls fetch meanwhile. Replacement state is only allowed to
// update while idle (hits) and on the fill-done cycle.
//
// Optional build macro: ICACHE_CRIT_WORD_FIRST_EN
//   Defined   : request the missed word first, fill the line in wrapping
//               order, release the stall after the first beat and add the
//               crit_valid_o port.
//   Undefined : line-order fill with the stall held until fill-done.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_n_i         asynchronous active-low reset
//   fetch_valid_i     fetch stage holds a valid pc_f_i
//   pc_f_i            fetch byte address
//   instr_hit_f_i     cache lookup hit for pc_f_i
//   flush_i           branch redirect; drops a request not yet accepted
//   mem_req_o         burst read request (held until mem_ready_i)
//   mem_addr_o        burst start byte address
//   mem_ready_i       memory accepted the request
//   mem_rvalid_i      read beat valid
//   mem_rdata_i       read beat data
//   ic_we_o           data-array write strobe
//   ic_waddr_o        byte address of the word written
//   ic_wdata_o        word written
//   ic_fill_done_o    one-cycle pulse: line complete, set tag/valid
//   ic_repl_permit_o  replacement state may update
//   stall_f_o         freeze PC and F/D registers
//   crit_valid_o      (macro only) registered pulse after the first beat
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int BLOCK_WORDS = IC_BLOCK_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              fetch_valid_i,
  input  logic [ADDR_W-1:0] pc_f_i,
  input  logic              instr_hit_f_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              ic_we_o,
  output logic [ADDR_W-1:0] ic_waddr_o,
  output logic [31:0]       ic_wdata_o,
  output logic              ic_fill_done_o,
  output logic              ic_repl_permit_o,
  output logic              stall_f_o
`ifdef ICACHE_CRIT_WORD_FIRST_EN
  ,
  output logic              crit_valid_o
`endif
);

  localparam int CW    = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  icache_refill_state_t state_reg, state_next;
  logic [ADDR_W-1:0]    base_reg, base_next;

  logic                 miss;
  logic                 start_miss;
  logic                 cnt_load;
  logic                 cnt_inc;
  logic                 cnt_last;
  logic [CW-1:0]        cnt_start;
  logic [CW-1:0]        cnt_val;
  logic [CW-1:0]        cnt_idx;
  logic [ADDR_W-1:0]    req_addr;
  logic [ADDR_W-1:0]    word_off;
  logic                 fill_stall;

  assign miss       = fetch_valid_i & ~instr_hit_f_i;
  assign start_miss = (state_reg == IDLE) & miss & ~flush_i;
  assign cnt_load   = (state_reg == REQ) & mem_ready_i;
  assign cnt_inc    = (state_reg == FILL) & mem_rvalid_i;
  assign cnt_last   = (cnt_val == CW'(BLOCK_WORDS - 1));
  assign word_off   = {{(ADDR_W-OFF_W){1'b0}}, cnt_idx, 2'b00};

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  logic [CW-1:0] off_reg;
  logic          crit_valid_reg;

  // Word offset of the missed PC; the burst starts there and wraps.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      off_reg        <= '0;
      crit_valid_reg <= 1'b0;
    end else begin
      if (start_miss) begin
        off_reg <= pc_f_i[OFF_W-1:2];
      end
      crit_valid_reg <= cnt_inc & (cnt_val == '0);
    end
  end

  assign cnt_start    = off_reg;
  assign req_addr     = base_reg | {{(ADDR_W-OFF_W){1'b0}}, off_reg, 2'b00};
  // Before the first beat fetch waits; afterwards only a fresh miss waits.
  assign fill_stall   = (cnt_val == '0) | miss;
  assign crit_valid_o = crit_valid_reg;
`else
  assign cnt_start  = '0;
  assign req_addr   = base_reg;
  assign fill_stall = 1'b1;
`endif

  icache_beat_counter #(
    .WORDS (BLOCK_WORDS)
  ) u_beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (cnt_load),
    .inc_i     (cnt_inc),
    .start_i   (cnt_start),
    .cnt_o     (cnt_val),
    .idx_o     (cnt_idx)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    base_next        = base_reg;
    mem_req_o        = 1'b0;
    mem_addr_o       = '0;
    ic_we_o          = 1'b0;
    ic_waddr_o       = '0;
    ic_wdata_o       = '0;
    ic_fill_done_o   = 1'b0;
    ic_repl_permit_o = 1'b0;
    stall_f_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        ic_repl_permit_o = 1'b1;
        stall_f_o        = miss;
        if (start_miss) begin
          base_next  = pc_f_i & LINE_MASK;
          state_next = REQ;
        end
      end

      REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = req_addr;
        stall_f_o  = 1'b1;
        // An accepted request wins over a simultaneous redirect.
        if (mem_ready_i) begin
          state_next = FILL;
        end else if (flush_i) begin
          state_next = IDLE;
        end
      end

      FILL: begin
        // A burst in flight cannot be cancelled, so flush_i is ignored here.
        stall_f_o = fill_stall;
        if (mem_rvalid_i) begin
          ic_we_o    = 1'b1;
          ic_waddr_o = base_reg | word_off;
          ic_wdata_o = mem_rdata_i;
          if (cnt_last) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        ic_fill_done_o   = 1'b1;
        ic_repl_permit_o = 1'b1;
        stall_f_o        = 1'b1;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
